// File: rtl/adpcm_pkg.sv
// adpcm_pkg: step-size and index-adjust tables plus clamp limits
// shared by the IMA ADPCM quantiser and the multi-channel codec top.
package adpcm_pkg;

  localparam logic signed [7:0] IDX_MAX = 8'sd88;
  localparam logic signed [17:0] PRED_MAX = 18'sd32767;
  localparam logic signed [17:0] PRED_MIN = -18'sd32768;

  localparam logic [14:0] STEP [89] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,
    15'd13,    15'd14,    15'd16,    15'd17,    15'd19,    15'd21,
    15'd23,    15'd25,    15'd28,    15'd31,    15'd34,    15'd37,
    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,
    15'd130,   15'd143,   15'd157,   15'd173,   15'd190,   15'd209,
    15'd230,   15'd253,   15'd279,   15'd307,   15'd337,   15'd371,
    15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,
    15'd1282,  15'd1411,  15'd1552,  15'd1707,  15'd1878,  15'd2066,
    15'd2272,  15'd2499,  15'd2749,  15'd3024,  15'd3327,  15'd3660,
    15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487,
    15'd12635, 15'd13899, 15'd15289, 15'd16818, 15'd18500, 15'd20350,
    15'd22385, 15'd24623, 15'd27086, 15'd29794, 15'd32767
  };

  localparam logic signed [7:0] IDX [8] = '{
    -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
  };

endpackage

// File: rtl/adpcm_quant.sv
// adpcm_quant: combinational IMA quantiser + inverse quantiser/update.
// In: valpred, index, x, dec_code, mode. Out: code, p, index_nx, sat.
// Decode selection exists only when ADPCM_DECODE_EN is defined.
import adpcm_pkg::*;

module adpcm_quant (
  input  logic signed [15:0] valpred,
  input  logic [6:0]         index,
  input  logic signed [15:0] x,
  input  logic [3:0]         dec_code,
  input  logic               mode,
  output logic [3:0]         code,
  output logic signed [15:0] p,
  output logic [6:0]         index_nx,
  output logic               sat
);

  logic [16:0] s17, diff, mag, m1, m2, vpdiff;
  logic [17:0] vp18, sum;
  logic        enc_sign, e2, e1, e0;
  logic        sign;
  logic [2:0]  bits;
  logic signed [7:0] ni;
  logic        hi, lo;

  assign s17 = {2'b00, STEP[index]};

  // 17-bit difference so full-scale swings cannot wrap
  assign diff = {x[15], x} - {valpred[15], valpred};
  assign enc_sign = diff[16];
  assign mag = enc_sign ? (17'd0 - diff) : diff;

  assign e2 = mag >= s17;
  assign m1 = e2 ? mag - s17 : mag;
  assign e1 = m1 >= (s17 >> 1);
  assign m2 = e1 ? m1 - (s17 >> 1) : m1;
  assign e0 = m2 >= (s17 >> 2);

`ifdef ADPCM_DECODE_EN
  assign sign = mode ? dec_code[3] : enc_sign;
  assign bits = mode ? dec_code[2:0] : {e2, e1, e0};
`else
  logic unused_dec;
  assign unused_dec = ^{mode, dec_code};
  assign sign = enc_sign;
  assign bits = {e2, e1, e0};
`endif

  assign code = {sign, bits};

  assign vpdiff = (s17 >> 3)
                + (bits[2] ? s17 : 17'd0)
                + (bits[1] ? (s17 >> 1) : 17'd0)
                + (bits[0] ? (s17 >> 2) : 17'd0);

  assign vp18 = {{2{valpred[15]}}, valpred};
  assign sum = sign ? vp18 - {1'b0, vpdiff}
                    : vp18 + {1'b0, vpdiff};

  assign hi = $signed(sum) > PRED_MAX;
  assign lo = $signed(sum) < PRED_MIN;
  assign sat = hi || lo;
  assign p = hi ? 16'sh7fff :
             lo ? 16'sh8000 : sum[15:0];

  assign ni = $signed({1'b0, index}) + IDX[bits];
  assign index_nx = ni < 8'sd0   ? 7'd0 :
                    ni > IDX_MAX ? 7'd88 : ni[6:0];

endmodule

// File: rtl/adpcm_codec_mc.sv
// adpcm_codec_mc: time-multiplexed multi-channel IMA ADPCM codec with
// per-channel state, clr, in/out valid-ready and one output register.
// Ports: clk, reset, mode, in_*, clr, clr_ch, out_*. Macro: ADPCM_DECODE_EN.
import adpcm_pkg::*;

module adpcm_codec_mc #(
  parameter int W   = 16,
  parameter int NCH = 4,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   in_sample,
  input  logic [3:0]     in_code,
  input  logic           clr,
  input  logic [CHW-1:0] clr_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [3:0]     out_code,
  output logic [W-1:0]   out_sample,
  output logic [6:0]     out_index,
  output logic           out_sat
);

  localparam int SH = 16 - W;
  localparam logic [CHW:0] NCH_V = (CHW+1)'(NCH);

  logic signed [15:0] pred_q [NCH];
  logic [6:0]         idx_q [NCH];

  logic acc, ch_ok, hit_clr, sat;
  logic signed [15:0] vp, x, p;
  logic [6:0] idx, idx_nx;
  logic [3:0] code;

  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign ch_ok = {1'b0, in_ch} < NCH_V;

  // a clear landing on the channel being processed forces zero state
  assign hit_clr = clr && (clr_ch == in_ch);
  assign vp  = hit_clr ? 16'sd0 : pred_q[in_ch];
  assign idx = hit_clr ? 7'd0 : idx_q[in_ch];
  assign x   = 16'(in_sample) << SH;

  adpcm_quant u_quant (
    .valpred  (vp),
    .index    (idx),
    .x        (x),
    .dec_code (in_code),
    .mode     (mode),
    .code     (code),
    .p        (p),
    .index_nx (idx_nx),
    .sat      (sat)
  );

  // accepted write is issued after the clear so it takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        pred_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      if (clr) begin
        pred_q[clr_ch] <= '0;
        idx_q[clr_ch]  <= '0;
      end
      if (acc && ch_ok) begin
        pred_q[in_ch] <= p;
        idx_q[in_ch]  <= idx_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_code   <= '0;
      out_sample <= '0;
      out_index  <= '0;
      out_sat    <= 1'b0;
    end else if (acc && ch_ok) begin
      out_valid  <= 1'b1;
      out_ch     <= in_ch;
      out_code   <= code;
      out_sample <= W'(p >>> SH);
      out_index  <= idx_nx;
      out_sat    <= sat;
    end else if (in_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
